wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: port 0 is the ALU/EX result, port 1 is the load/MEM result.
- Holds one pending result per requester and picks a winner each cycle, oldest first with round-robin on ties.
- Drives the register file write port (w_addr/w_data/we) from registered outputs.
- Keeps a per-register busy scoreboard that decode queries to stall on RAW hazards.

Parameters:
- REG_CNT, 32, number of architectural registers; x0 is hardwired zero.
- ADDR_W, 5, register address width (log2 REG_CNT).
- DATA_W, 32, register data width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req0_valid  in  1  EX result valid.
- req0_rd  in  ADDR_W  EX destination register.
- req0_data  in  DATA_W  EX result.
- req0_ready  out  1  EX result accepted this cycle when high with valid.
- req1_valid, req1_rd, req1_data, req1_ready  same as port 0, for the MEM/load result.
- issue_valid  in  1  decode issued an instruction that writes issue_rd.
- issue_rd  in  ADDR_W  destination register of the issued instruction.
- rs1_addr, rs2_addr  in  ADDR_W  scoreboard query addresses.
- rs1_busy, rs2_busy  out  1  queried register has a write outstanding.
- we  out  1  register file write enable.
- w_addr  out  ADDR_W  register file write address.
- w_data  out  DATA_W  register file write data.
- idle  out  1  no held result and we low.

Behaviour:
- Clocking and reset: clk only. rst is synchronous and active-high and overrides everything.
- Reset values:
  - we=0, w_addr=0, w_data=0.
  - Both hold registers invalid; all busy bits 0.
  - Tie pointer favours port 0 next.
  - reqN_ready=0 while rst is high; idle=1 after reset.
- Hold registers: one entry per port (valid, rd, data, age bit).
  - reqN_ready = !holdN_valid | grantN, combinational, so a port can sustain 1 result per cycle.
  - Accept on the clock edge where valid & ready.
- rd==0 requests:
  - Accepted with ready=1 but never enter the hold register.
  - No we pulse and no scoreboard effect.
- Arbitration (combinational, every cycle, over valid holds):
  - Exactly one valid hold: it wins.
  - Both valid, different ages: the older one wins. An entry is older if it was held at the edge the other was accepted.
  - Both valid, same age (accepted the same edge): the tie pointer decides. The pointer toggles to the other port after each tie grant.
- Output stage: at each edge with a winner:
  - we<=1, w_addr<=winner rd, w_data<=winner data; the winner's hold is cleared (or refilled by a same-edge accept).
  - With no winner: we<=0, and w_addr/w_data hold their values.
- Latency: request accepted at edge E0 → we high in the cycle after E1 → register file commits at E2. Register file read bypass covers the E1–E2 cycle.
- Scoreboard:
  - At an edge, issue_valid with issue_rd!=0 sets busy[issue_rd].
  - At an edge, loading the output stage clears busy[w_addr].
  - Set and clear of the same rd at the same edge: set wins (the newer instruction is pending).
- Query outputs:
  - rsN_busy = busy[rsN_addr], combinational.
  - rsN_addr==0 gives 0.
- Loser behaviour: a losing hold keeps its value and its port's ready stays low; the requester stalls.
- Reset mid-operation: pending holds and the output stage are discarded and all busy bits are cleared. The pipeline flushes alongside.

Decomposition:
- Shared define file: REG_CNT, ADDR_W, DATA_W, and the zero-register constant. Reuse the existing RegAddrBus/RegBus/RegCnt defines.
- Natural sub-module: wb_scoreboard (busy vector; set/clear/query ports).
- The arbiter, hold registers and output stage stay in wb_arbiter.

Test Plan:
- Reset with rst high for 2 cycles → we=0, w_addr=0, w_data=0, rs1_busy=0 for every address, idle=1, readies 0 during reset and 1 after.
- Single write: issue_rd=5, then req0 rd=5 data=0xDEADBEEF.
  - rs1_addr=5 busy=1 from the edge after issue.
  - we=1, w_addr=5, w_data=0xDEADBEEF exactly 1 cycle after accept; rs1_busy drops in the same cycle.
- Same-age contention: req0 (rd=3, 0x11) and req1 (rd=4, 0x22) accepted the same edge.
  - Port 0 writes first, then port 1.
  - Repeat: port 1 first.
  - req1_ready is low during the stalled cycle.
- Age ordering: req1 rd=7 accepted at cycle 0, req0 rd=7 accepted at cycle 1 while req1 still held → req1 data writes before req0 data; final x7 value = req0 data.
- rd=0: req0 rd=0 data=0xFFFFFFFF → ready=1, we never asserts, rs1_addr=0 busy=0.
- Scoreboard conflict: issue_rd=9 on the same edge that rd=9 is loaded to the output → busy[9] stays 1. Reset asserted with both holds valid → no we after reset, all busy 0.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared register-file widths, hold-register type and helpers for the writeback arbiter.
package wb_arbiter_pkg;

    localparam int REG_CNT = 32;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    localparam reg_addr_t REG_ZERO = '0;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_t;

    // old is set once the other port has been accepted while this entry waited.
    typedef struct packed {
        logic      valid;
        logic      old;
        reg_addr_t rd;
        reg_data_t data;
    } hold_t;

    function automatic hold_t next_hold(hold_t cur, logic acc, logic grt, logic other_acc,
                                        reg_addr_t rd, reg_data_t data);
        hold_t nxt;
        nxt = cur;
        if (acc) begin
            nxt.valid = (rd != REG_ZERO);
            nxt.old   = 1'b0;
            nxt.rd    = rd;
            nxt.data  = data;
        end else if (grt) begin
            nxt.valid = 1'b0;
        end else if (other_acc && cur.valid) begin
            nxt.old = 1'b1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus: two result requesters, decode issue/query and the register file write port.
interface wb_arbiter_if;
    import wb_arbiter_pkg::*;

    logic      req0_valid;
    reg_addr_t req0_rd;
    reg_data_t req0_data;
    logic      req0_ready;
    logic      req1_valid;
    reg_addr_t req1_rd;
    reg_data_t req1_data;
    logic      req1_ready;
    logic      issue_valid;
    reg_addr_t issue_rd;
    reg_addr_t rs1_addr;
    reg_addr_t rs2_addr;
    logic      rs1_busy;
    logic      rs2_busy;
    logic      we;
    reg_addr_t w_addr;
    reg_data_t w_data;
    logic      idle;

    modport master (
        output req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data,
        output issue_valid, issue_rd, rs1_addr, rs2_addr,
        input  req0_ready, req1_ready, rs1_busy, rs2_busy, we, w_addr, w_data, idle
    );

    modport slave (
        input  req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data,
        input  issue_valid, issue_rd, rs1_addr, rs2_addr,
        output req0_ready, req1_ready, rs1_busy, rs2_busy, we, w_addr, w_data, idle
    );

endinterface

// File: rtl/wb_scoreboard.sv
// Per-register busy bits: set on issue, cleared when the write reaches the output stage.
module wb_scoreboard
    import wb_arbiter_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      set_en,
    input  reg_addr_t set_addr,
    input  logic      clr_en,
    input  reg_addr_t clr_addr,
    input  reg_addr_t rs1_addr,
    input  reg_addr_t rs2_addr,
    output logic      rs1_busy,
    output logic      rs2_busy
);

    logic [REG_CNT-1:0] busy;

    // The set is written last so a newly issued writer keeps its register busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (clr_en) begin
                busy[clr_addr] <= 1'b0;
            end
            if (set_en && (set_addr != REG_ZERO)) begin
                busy[set_addr] <= 1'b1;
            end
        end
    end

    assign rs1_busy = (rs1_addr != REG_ZERO) && busy[rs1_addr];
    assign rs2_busy = (rs2_addr != REG_ZERO) && busy[rs2_addr];

endmodule

// File: rtl/wb_arbiter.sv
// Two-port writeback arbiter: oldest-first with round-robin ties, registered write port.
module wb_arbiter
    import wb_arbiter_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);

    hold_t      hold0;
    hold_t      hold1;
    hold_t      win_hold;
    port_t      tie_ptr;
    port_t      winner;
    logic       win_any;
    logic       tie;
    logic [1:0] grant;
    logic [1:0] ready;
    logic [1:0] accept;

    always_comb begin
        grant   = '0;
        win_any = 1'b0;
        tie     = 1'b0;
        winner  = PORT0;
        if (hold0.valid && hold1.valid) begin
            win_any = 1'b1;
            if (hold0.old != hold1.old) begin
                winner = hold1.old ? PORT1 : PORT0;
            end else begin
                tie    = 1'b1;
                winner = tie_ptr;
            end
        end else if (hold0.valid) begin
            win_any = 1'b1;
            winner  = PORT0;
        end else if (hold1.valid) begin
            win_any = 1'b1;
            winner  = PORT1;
        end
        grant[0] = win_any && (winner == PORT0);
        grant[1] = win_any && (winner == PORT1);
    end

    assign win_hold = (winner == PORT1) ? hold1 : hold0;

    // A port may take a new result whenever its slot is empty or leaving this edge.
    assign ready[0]  = !rst && (!hold0.valid || grant[0]);
    assign ready[1]  = !rst && (!hold1.valid || grant[1]);
    assign accept[0] = bus.req0_valid && ready[0];
    assign accept[1] = bus.req1_valid && ready[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            hold0   <= '0;
            hold1   <= '0;
            tie_ptr <= PORT0;
        end else begin
            hold0 <= next_hold(hold0, accept[0], grant[0], accept[1], bus.req0_rd, bus.req0_data);
            hold1 <= next_hold(hold1, accept[1], grant[1], accept[0], bus.req1_rd, bus.req1_data);
            if (tie) begin
                tie_ptr <= (winner == PORT0) ? PORT1 : PORT0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.we     <= 1'b0;
            bus.w_addr <= '0;
            bus.w_data <= '0;
        end else begin
            bus.we <= win_any;
            if (win_any) begin
                bus.w_addr <= win_hold.rd;
                bus.w_data <= win_hold.data;
            end
        end
    end

    assign bus.req0_ready = ready[0];
    assign bus.req1_ready = ready[1];
    assign bus.idle       = !hold0.valid && !hold1.valid && !bus.we;

    wb_scoreboard u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (bus.issue_valid),
        .set_addr (bus.issue_rd),
        .clr_en   (win_any),
        .clr_addr (win_hold.rd),
        .rs1_addr (bus.rs1_addr),
        .rs2_addr (bus.rs2_addr),
        .rs1_busy (bus.rs1_busy),
        .rs2_busy (bus.rs2_busy)
    );

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: expected writes are queued and matched as we pulses appear.
module tb_wb_arbiter;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic   clk;
    logic   rst;
    exp_t   exp_q[$];
    exp_t   mon_exp;
    int     assertions;
    int     failures;

    wb_arbiter_if bus();

    wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                                 input logic v1, input logic [4:0] rd1, input logic [31:0] d1);
        bus.req0_valid = v0;
        bus.req0_rd    = rd0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_rd    = rd1;
        bus.req1_data  = d1;
    endtask

    task automatic pushExp(input logic [4:0] rd, input logic [31:0] data);
        exp_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Every write the DUT issues must match the next queued expectation.
    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_we", {63'd0, bus.we}, 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                checkOutput("w_addr", {59'd0, bus.w_addr}, {59'd0, mon_exp.rd});
                checkOutput("w_data", {32'd0, bus.w_data}, {32'd0, mon_exp.data});
            end
        end
    end

    initial begin
        assertions = 0;
        failures   = 0;
        rst        = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.rs1_addr    = '0;
        bus.rs2_addr    = '0;

        tick();
        checkOutput("rst_ready0", {63'd0, bus.req0_ready}, 64'd0);
        checkOutput("rst_ready1", {63'd0, bus.req1_ready}, 64'd0);
        checkOutput("rst_we", {63'd0, bus.we}, 64'd0);
        checkOutput("rst_w_addr", {59'd0, bus.w_addr}, 64'd0);
        checkOutput("rst_w_data", {32'd0, bus.w_data}, 64'd0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("post_rst_ready0", {63'd0, bus.req0_ready}, 64'd1);
        checkOutput("post_rst_ready1", {63'd0, bus.req1_ready}, 64'd1);
        checkOutput("post_rst_idle", {63'd0, bus.idle}, 64'd1);
        for (int a = 0; a < 32; a++) begin
            bus.rs1_addr = a[4:0];
            #0;
            checkOutput("post_rst_busy", {63'd0, bus.rs1_busy}, 64'd0);
        end

        // Single write with a scoreboard hazard on x5
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd5;
        tick();
        bus.issue_valid = 1'b0;
        bus.rs1_addr    = 5'd5;
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        pushExp(5'd5, 32'hDEADBEEF);
        #1;
        checkOutput("busy5_after_issue", {63'd0, bus.rs1_busy}, 64'd1);
        checkOutput("single_ready0", {63'd0, bus.req0_ready}, 64'd1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #1;
        checkOutput("single_we_early", {63'd0, bus.we}, 64'd0);
        checkOutput("busy5_held", {63'd0, bus.rs1_busy}, 64'd1);
        tick();
        checkOutput("single_we", {63'd0, bus.we}, 64'd1);
        checkOutput("single_w_addr", {59'd0, bus.w_addr}, 64'd5);
        checkOutput("busy5_cleared", {63'd0, bus.rs1_busy}, 64'd0);
        tick();

        // Same-age contention: port 0 first, then port 1 first on the next tie
        applyStimulus(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
        pushExp(5'd3, 32'h11);
        pushExp(5'd4, 32'h22);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #1;
        checkOutput("tie1_ready1_stall", {63'd0, bus.req1_ready}, 64'd0);
        checkOutput("tie1_ready0", {63'd0, bus.req0_ready}, 64'd1);
        tick();
        tick();
        tick();
        applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
        pushExp(5'd4, 32'h44);
        pushExp(5'd3, 32'h33);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #1;
        checkOutput("tie2_ready0_stall", {63'd0, bus.req0_ready}, 64'd0);
        tick();
        tick();
        tick();

        // Age ordering on x7; the final age decision disagrees with the tie pointer
        applyStimulus(1'b1, 5'd6, 32'h60, 1'b1, 5'd7, 32'h71);
        pushExp(5'd6, 32'h60);
        pushExp(5'd7, 32'h71);
        pushExp(5'd7, 32'h70);
        pushExp(5'd8, 32'h81);
        tick();
        applyStimulus(1'b1, 5'd7, 32'h70, 1'b0, 5'd0, 32'd0);
        #1;
        checkOutput("age_ready0", {63'd0, bus.req0_ready}, 64'd1);
        checkOutput("age_ready1_stall", {63'd0, bus.req1_ready}, 64'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h81);
        #1;
        checkOutput("age_ready1", {63'd0, bus.req1_ready}, 64'd1);
        checkOutput("age_ready0_stall", {63'd0, bus.req0_ready}, 64'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        checkOutput("age_final_x7", {32'd0, bus.w_data}, 64'h70);
        tick();
        tick();
        checkOutput("age_idle", {63'd0, bus.idle}, 64'd1);

        // rd==0 is swallowed: no write, no busy
        applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0);
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd0;
        #1;
        checkOutput("rd0_ready0", {63'd0, bus.req0_ready}, 64'd1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        bus.issue_valid = 1'b0;
        bus.rs1_addr    = 5'd0;
        #1;
        checkOutput("rd0_busy", {63'd0, bus.rs1_busy}, 64'd0);
        checkOutput("rd0_idle", {63'd0, bus.idle}, 64'd1);
        tick();
        checkOutput("rd0_no_we", {63'd0, bus.we}, 64'd0);

        // Issue of x9 on the edge its older write is loaded keeps x9 busy
        applyStimulus(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0);
        pushExp(5'd9, 32'h99);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd9;
        tick();
        bus.issue_valid = 1'b0;
        bus.rs1_addr    = 5'd9;
        #1;
        checkOutput("busy9_set_wins", {63'd0, bus.rs1_busy}, 64'd1);
        tick();

        // Reset with both holds valid discards them and clears the scoreboard
        applyStimulus(1'b1, 5'd11, 32'hB0, 1'b1, 5'd12, 32'hC0);
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd13;
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        bus.issue_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_ready0", {63'd0, bus.req0_ready}, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("mid_rst_we", {63'd0, bus.we}, 64'd0);
        checkOutput("mid_rst_idle", {63'd0, bus.idle}, 64'd1);
        for (int a = 0; a < 32; a++) begin
            bus.rs1_addr = a[4:0];
            bus.rs2_addr = a[4:0];
            #0;
            checkOutput("mid_rst_busy1", {63'd0, bus.rs1_busy}, 64'd0);
            checkOutput("mid_rst_busy2", {63'd0, bus.rs2_busy}, 64'd0);
        end
        tick();
        tick();
        tick();
        checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
